// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: decodes SPI command/data byte pairs into register write/read strobes
//
// Ports:
//   clk        peripheral clock
//   rst_n      synchronous active-low reset
//   cs_n       raw SPI chip select (synchronized internally, 2 flops)
//   byte_sync  one-cycle pulse, data_in valid in the same cycle
//   data_in    received byte
//   data_out   byte for the bridge to transmit next (registered)
//   reg_addr   register address (registered)
//   reg_wdata  write data (registered)
//   reg_we     one-cycle write strobe
//   reg_re     one-cycle read strobe
//   reg_rdata  combinational read data, valid during reg_re
//   cmd_err    one-cycle pulse on access to an illegal address
//
// Build option: define SPI_REG_AUTOINC_EN for burst mode (address auto-increment
// after every data/dummy byte until cs_n rises).
module spi_reg_ctrl #(
    parameter int ADDR_W   = 6,
    parameter int NUM_REGS = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              byte_sync,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              cmd_err
);
`ifdef SPI_REG_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef enum logic [1:0] {CMD, WDATA, RDATA} state_t;

    state_t            state, state_n;
    logic              cs_meta, cs_sync;
    logic [ADDR_W-1:0] addr_n, cmd_addr, addr_inc;
    logic [7:0]        wdata_n, dout_n;
    logic              we_n, re_n, err_n, take;

    function automatic logic legal(input logic [ADDR_W-1:0] a);
        return int'(a) < NUM_REGS;
    endfunction

    assign cmd_addr = data_in[ADDR_W-1:0];
    assign addr_inc = reg_addr + ADDR_W'(1);
    // a byte arriving while any strobe is out is dropped
    assign take     = byte_sync && !(reg_we || reg_re || cmd_err);

    always_comb begin
        state_n = state;
        addr_n  = reg_addr;
        wdata_n = reg_wdata;
        dout_n  = data_out;
        we_n    = 1'b0;
        re_n    = 1'b0;
        err_n   = 1'b0;
        case (state)
            CMD: begin
                dout_n = 8'h00;
                if (take) begin
                    addr_n = cmd_addr;
                    if (data_in[7]) begin
                        state_n = WDATA;
                    end else begin
                        state_n = RDATA;
                        re_n    = 1'b1;
                        err_n   = !legal(cmd_addr);
                    end
                end
            end
            WDATA: if (take) begin
                wdata_n = data_in;
                we_n    = legal(reg_addr);
                err_n   = !legal(reg_addr);
                state_n = AUTOINC ? WDATA : CMD;
            end
            RDATA: if (take) begin
                dout_n = 8'h00;
                if (AUTOINC) begin
                    addr_n = addr_inc;
                    re_n   = 1'b1;
                    err_n  = !legal(addr_inc);
                end else begin
                    state_n = CMD;
                end
            end
            default: state_n = CMD;
        endcase
        // burst writes advance the address once the current write strobe is out
        if (AUTOINC && state == WDATA && (reg_we || cmd_err))
            addr_n = addr_inc;
        if (reg_re)
            dout_n = legal(reg_addr) ? reg_rdata : 8'h00;
        // a byte coinciding with deselect completes; the force lands a cycle later
        if (cs_sync && !take) begin
            state_n = CMD;
            dout_n  = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            state     <= CMD;
            reg_addr  <= '0;
            reg_wdata <= 8'h00;
            data_out  <= 8'h00;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            cs_meta   <= cs_n;
            cs_sync   <= cs_meta;
            state     <= state_n;
            reg_addr  <= addr_n;
            reg_wdata <= wdata_n;
            data_out  <= dout_n;
            reg_we    <= we_n;
            reg_re    <= re_n;
            cmd_err   <= err_n;
        end
    end
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: scoreboard bench for spi_reg_ctrl strobes and read data
module tb_spi_reg_ctrl;
`ifdef SPI_REG_AUTOINC_EN
    localparam int NR = 64;
`else
    localparam int NR = 20;
`endif

    typedef struct packed {
        logic [1:0] kind;
        logic [5:0] addr;
        logic [7:0] data;
    } exp_t;

    localparam logic [1:0] K_WR = 2'd0, K_RD = 2'd1, K_ERR = 2'd2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs_n = 1'b1;
    logic       byte_sync = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out, reg_wdata, reg_rdata;
    logic [5:0] reg_addr;
    logic       reg_we, reg_re, cmd_err;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    assign reg_rdata = (reg_addr == 6'd3) ? 8'h3C : {2'b10, reg_addr};

    spi_reg_ctrl #(.ADDR_W(6), .NUM_REGS(NR)) dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .byte_sync(byte_sync),
        .data_in(data_in), .data_out(data_out), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .cmd_err(cmd_err)
    );

    always @(negedge clk) begin
        exp_t e;
        if (reg_we && reg_re) begin
            n_checks++;
            n_fail++;
            $display("FAIL we_re_overlap: reg_we=%b reg_re=%b required not both", reg_we, reg_re);
        end
        if (reg_we) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_we: addr=%0d wdata=%h required no write", reg_addr, reg_wdata);
            end else begin
                e = q.pop_front();
                if (e.kind !== K_WR || e.addr !== reg_addr || e.data !== reg_wdata) begin
                    n_fail++;
                    $display("FAIL write_strobe: got addr=%0d wdata=%h, required kind=%0d addr=%0d wdata=%h",
                             reg_addr, reg_wdata, e.kind, e.addr, e.data);
                end
            end
        end
        if (reg_re) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_re: addr=%0d required no read", reg_addr);
            end else begin
                e = q.pop_front();
                if (e.kind !== K_RD || e.addr !== reg_addr) begin
                    n_fail++;
                    $display("FAIL read_strobe: got addr=%0d, required kind=%0d addr=%0d", reg_addr, e.kind, e.addr);
                end
            end
        end
        if (cmd_err) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_err: addr=%0d required no cmd_err", reg_addr);
            end else begin
                e = q.pop_front();
                if (e.kind !== K_ERR) begin
                    n_fail++;
                    $display("FAIL cmd_err: got cmd_err, required kind=%0d addr=%0d", e.kind, e.addr);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_sync = 1'b1;
        data_in   = b;
        @(negedge clk);
        byte_sync = 1'b0;
        idle(8);
    endtask

    task automatic frame_end(input string name);
        idle(4);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending: %0d expected strobes not seen, required 0", name, q.size());
            q.delete();
        end
        cs_n = 1'b1;
        idle(6);
        cs_n = 1'b0;
        idle(6);
    endtask

    task automatic test_reset;
        n_checks++;
        if ({data_out, reg_addr, reg_wdata, reg_we, reg_re, cmd_err} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_values: dout=%h addr=%0d wdata=%h we=%b re=%b err=%b required all 0",
                     data_out, reg_addr, reg_wdata, reg_we, reg_re, cmd_err);
        end
    endtask

    task automatic test_write;
        q.push_back('{kind: K_WR, addr: 6'd5, data: 8'hA5});
        send_byte(8'h85);
        send_byte(8'hA5);
        n_checks++;
        if (data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL write_dout: data_out=%h required 00", data_out);
        end
        // a fresh read right after proves the FSM went back to CMD
        q.push_back('{kind: K_RD, addr: 6'd5, data: 8'h00});
        send_byte(8'h05);
        n_checks++;
        if (data_out !== 8'h85) begin
            n_fail++;
            $display("FAIL write_then_read: data_out=%h required 85", data_out);
        end
        send_byte(8'h00);
        frame_end("write");
    endtask

    task automatic test_read;
        q.push_back('{kind: K_RD, addr: 6'd3, data: 8'h00});
        @(negedge clk);
        byte_sync = 1'b1;
        data_in   = 8'h03;
        @(negedge clk);
        byte_sync = 1'b0;
        n_checks++;
        if (data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL read_t1: data_out=%h required 00", data_out);
        end
        @(negedge clk);
        n_checks++;
        if (data_out !== 8'h3C) begin
            n_fail++;
            $display("FAIL read_t2: data_out=%h required 3c", data_out);
        end
        idle(6);
        @(negedge clk);
        byte_sync = 1'b1;
        data_in   = 8'hEE;
        @(negedge clk);
        byte_sync = 1'b0;
        n_checks++;
        if (data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL read_after_dummy: data_out=%h required 00", data_out);
        end
        idle(6);
        frame_end("read");
    endtask

    task automatic test_illegal;
        q.push_back('{kind: K_ERR, addr: 6'd22, data: 8'h11});
        send_byte(8'h96);
        send_byte(8'h11);
        q.push_back('{kind: K_RD, addr: 6'd22, data: 8'h00});
        q.push_back('{kind: K_ERR, addr: 6'd22, data: 8'h00});
        send_byte(8'h16);
        n_checks++;
        if (data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL illegal_read_dout: data_out=%h required 00", data_out);
        end
        send_byte(8'h00);
        frame_end("illegal");
    endtask

    task automatic test_abort;
        send_byte(8'h85);
        cs_n = 1'b1;
        idle(6);
        cs_n = 1'b0;
        idle(6);
        q.push_back('{kind: K_WR, addr: 6'd2, data: 8'h7F});
        send_byte(8'h82);
        send_byte(8'h7F);
        frame_end("abort");
    endtask

    task automatic test_mid_reset;
        send_byte(8'h85);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({data_out, reg_addr, reg_wdata, reg_we, reg_re, cmd_err} !== 33'd0) begin
            n_fail++;
            $display("FAIL mid_reset_values: dout=%h addr=%0d wdata=%h we=%b re=%b err=%b required all 0",
                     data_out, reg_addr, reg_wdata, reg_we, reg_re, cmd_err);
        end
        rst_n = 1'b1;
        idle(6);
        // 0xA5 now acts as a write command to addr 37, so 0x00 draws cmd_err
        send_byte(8'hA5);
        q.push_back('{kind: K_ERR, addr: 6'd37, data: 8'h00});
        send_byte(8'h00);
        frame_end("mid_reset");
    endtask

    task automatic test_back_to_back;
        q.push_back('{kind: K_WR, addr: 6'd1, data: 8'h11});
        send_byte(8'h81);
        @(negedge clk);
        byte_sync = 1'b1;
        data_in   = 8'h11;
        @(negedge clk);
        // this byte lands in the reg_we cycle and must be dropped
        data_in = 8'hFF;
        @(negedge clk);
        byte_sync = 1'b0;
        idle(8);
        q.push_back('{kind: K_RD, addr: 6'd1, data: 8'h00});
        send_byte(8'h01);
        n_checks++;
        if (data_out !== 8'h81) begin
            n_fail++;
            $display("FAIL b2b_read: data_out=%h required 81", data_out);
        end
        send_byte(8'h00);
        frame_end("back_to_back");
    endtask

    task automatic test_burst;
        send_byte(8'hBF);
        q.push_back('{kind: K_WR, addr: 6'd63, data: 8'h01});
        send_byte(8'h01);
        q.push_back('{kind: K_WR, addr: 6'd0, data: 8'h02});
        send_byte(8'h02);
        frame_end("burst");
    endtask

    initial begin
        idle(3);
        rst_n = 1'b1;
        test_reset;
        cs_n = 1'b0;
        idle(6);
`ifdef SPI_REG_AUTOINC_EN
        test_burst;
`else
        test_write;
        test_read;
        test_illegal;
        test_abort;
        test_mid_reset;
        test_back_to_back;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
